// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: 64-entry FIFO wrapped around a single-port block RAM with a registered
// 1-cycle read. At most one RAM access per cycle; a head fetch takes priority over a write.
module ram_fifo_ctrl #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ram_en,
    output logic          ram_we,
    output logic          ram_clr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do
);

    localparam int unsigned DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          inflight;
    logic          fetch;
    logic          wr_fire;
    logic          rd_fire;

    // Occupancy covers entries in the RAM, the one being read, and the output register.
    assign count = ram_cnt + (AW + 1)'(inflight) + (AW + 1)'(rd_valid);
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    assign fetch    = !rd_valid && !inflight && (ram_cnt != '0) && !flush;
    // CLR gating keeps the RAM port and the write handshake quiet while reset is held.
    assign wr_ready = CLR && !fetch && !flush && !full;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_clr  = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (CLR) begin
            if (flush) begin
                ram_en  = 1'b1;
                ram_clr = 1'b1;
            end else if (fetch) begin
                ram_en   = 1'b1;
                ram_addr = rd_ptr;
            end else if (wr_fire) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = wr_ptr;
                ram_di   = wr_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr  <= wr_ptr + 1'b1;
                ram_cnt <= ram_cnt + 1'b1;
            end else if (fetch) begin
                rd_ptr  <= rd_ptr + 1'b1;
                ram_cnt <= ram_cnt - 1'b1;
            end

            // inflight and rd_valid are never both set, so capture and consume cannot collide.
            if (inflight) begin
                rd_data  <= ram_do;
                rd_valid <= 1'b1;
                inflight <= 1'b0;
            end else begin
                inflight <= fetch;
                if (rd_fire) begin
                    rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural 64x16 RAM, scoreboard queue filled on write handshakes
// and drained on read handshakes, plus directed checks of latency, flush and reset.
module tb_ram_fifo_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 16;

    logic          CLK = 1'b0;
    logic          CLR;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ram_en;
    logic          ram_we;
    logic          ram_clr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] sb [$];
    logic [AW-1:0] m_wr_ptr;
    logic [AW-1:0] m_rd_ptr;
    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;

    always #5 CLK = ~CLK;

    ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .flush    (flush),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_clr  (ram_clr),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    // Single-port RAM: synchronous write, registered read, synchronous output clear.
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_clr) ram_do <= '0;
            else if (ram_we) mem[ram_addr] <= ram_di;
            else ram_do <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor on the falling edge: inputs and outputs are settled for the coming rising edge.
    always @(negedge CLK) begin
        logic [DW-1:0] exp;
        if (!CLR) begin
            check("rst_rd_valid", 32'(rd_valid), 32'(0));
            check("rst_count", 32'(count), 32'(0));
            check("rst_empty", 32'(empty), 32'(1));
            check("rst_full", 32'(full), 32'(0));
            check("rst_ram_ctl", 32'({ram_en, ram_we, ram_clr}), 32'(0));
            check("rst_rd_data", 32'(rd_data), 32'(0));
            sb.delete();
            m_wr_ptr = '0;
            m_rd_ptr = '0;
        end else begin
            check("count", 32'(count), 32'(sb.size()));
            check("full", 32'(full), 32'(sb.size() == 64));
            check("empty", 32'(empty), 32'(sb.size() == 0));
            check("ram_clr", 32'(ram_clr), 32'(flush));
            check("wr_ready", 32'(wr_ready),
                  32'(!flush && !(ram_en && !ram_we) && sb.size() < 64));
            if (flush) begin
                check("flush_ram_en", 32'(ram_en), 32'(1));
                sb.delete();
                m_wr_ptr = '0;
                m_rd_ptr = '0;
            end else begin
                if (ram_en && !ram_we) begin
                    check("fetch_addr", 32'(ram_addr), 32'(m_rd_ptr));
                    m_rd_ptr++;
                end
                if (wr_valid && wr_ready) begin
                    check("wr_ram_ctl", 32'({ram_en, ram_we}), 32'(3));
                    check("wr_addr", 32'(ram_addr), 32'(m_wr_ptr));
                    check("wr_di", 32'(ram_di), 32'(wr_data));
                    sb.push_back(wr_data);
                    m_wr_ptr++;
                end
                if (rd_valid && rd_ready) begin
                    check("pop_nonempty", 32'(sb.size() != 0), 32'(1));
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("rd_data", 32'(rd_data), 32'(exp));
                        pops++;
                    end
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && n < 20) begin
            step();
            n++;
        end
        check("push_accept", 32'(wr_ready), 32'(1));
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_valid();
        int n;
        n = 0;
        while (!rd_valid && n < 20) begin
            step();
            n++;
        end
        check("rd_valid_wait", 32'(rd_valid), 32'(1));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (count != '0 && n < budget) begin
            step();
            n++;
        end
        rd_ready = 1'b0;
        check("drain_done", 32'(count), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int stalls;
        logic [DW-1:0] d;

        // Reset held with random inputs.
        CLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush    = 1'($urandom());
            wr_valid = 1'($urandom());
            rd_ready = 1'($urandom());
            wr_data  = 16'($urandom());
            step();
        end
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;
        CLR      = 1'b1;
        #1;
        check("post_rst_wr_ready", 32'(wr_ready), 32'(1));
        step();

        // Single entry latency.
        wr_valid = 1'b1;
        wr_data  = 16'hA5A5;
        check("single_wr_ready", 32'(wr_ready), 32'(1));
        step();
        wr_valid = 1'b0;
        check("single_fetch", 32'({ram_en, ram_we}), 32'(2));
        check("single_fetch_addr", 32'(ram_addr), 32'(0));
        step();
        check("single_cyc2_rd_valid", 32'(rd_valid), 32'(0));
        step();
        check("single_cyc3_rd_valid", 32'(rd_valid), 32'(1));
        check("single_rd_data", 32'(rd_data), 32'(16'hA5A5));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("single_count", 32'(count), 32'(0));
        check("single_empty", 32'(empty), 32'(1));

        // Fill to 64, try a 65th, then drain in order.
        for (int i = 0; i < 64; i++) push(16'(i));
        check("fill_full", 32'(full), 32'(1));
        check("fill_count", 32'(count), 32'(64));
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        #1;
        check("fill_wr_ready", 32'(wr_ready), 32'(0));
        step();
        step();
        wr_valid = 1'b0;
        check("fill_count_hold", 32'(count), 32'(64));
        p0 = pops;
        drain(300);
        check("fill_pops", 32'(pops - p0), 32'(64));

        // 70 more words streamed through, crossing the pointer wrap.
        p0 = pops;
        rd_ready = 1'b1;
        for (int i = 0; i < 70; i++) push(16'(16'h1000 + i));
        drain(300);
        check("wrap_pops", 32'(pops - p0), 32'(70));

        // Arbitration: write held high while reading.
        p0 = pops;
        stalls = 0;
        d = 16'h2000;
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wr_data = d;
            if (wr_ready) d++;
            else stalls++;
            step();
        end
        wr_valid = 1'b0;
        check("arb_stalled", 32'(stalls > 0), 32'(1));
        drain(300);
        check("arb_pops", 32'(pops - p0), 32'(d - 16'h2000));

        // Flush with 10 stored and a capture in flight.
        for (int i = 0; i < 10; i++) push(16'(16'h3000 + i));
        wait_rd_valid();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("flush_pre_fetch", 32'({ram_en, ram_we}), 32'(2));
        step();
        flush = 1'b1;
        #1;
        check("flush_ram_ctl", 32'({ram_en, ram_we, ram_clr}), 32'(5));
        check("flush_wr_ready", 32'(wr_ready), 32'(0));
        check("flush_count_before", 32'(count), 32'(9));
        step();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'(0));
        check("flush_rd_valid", 32'(rd_valid), 32'(0));
        check("flush_rd_data", 32'(rd_data), 32'(0));
        step();
        step();
        check("flush_no_capture", 32'(rd_valid), 32'(0));
        push(16'h1234);
        wait_rd_valid();
        check("flush_readback", 32'(rd_data), 32'(16'h1234));
        drain(20);

        // Reset during a fetch with 5 entries stored.
        for (int i = 0; i < 6; i++) push(16'(16'h4000 + i));
        wait_rd_valid();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("mid_rst_fetch", 32'({ram_en, ram_we}), 32'(2));
        check("mid_rst_count_before", 32'(count), 32'(5));
        CLR = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_rd_valid", 32'(rd_valid), 32'(0));
        check("mid_rst_flags", 32'({full, empty}), 32'(1));
        check("mid_rst_ram_ctl", 32'({ram_en, ram_we, ram_clr}), 32'(0));
        step();
        step();
        CLR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_no_capture", 32'({rd_valid, count}), 32'(0));
            step();
        end
        push(16'hBEEF);
        wait_rd_valid();
        check("mid_rst_readback", 32'(rd_data), 32'(16'hBEEF));
        drain(20);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
